// File: rtl/max7219_pkg.sv
// MAX7219 register map, Code-B constants and controller state types.
// Shared by the frame serializer and the frame sequencer.
package max7219_pkg;

  localparam logic [3:0] DIGIT0    = 4'h1;
  localparam logic [3:0] DIGIT1    = 4'h2;
  localparam logic [3:0] DIGIT2    = 4'h3;
  localparam logic [3:0] DIGIT3    = 4'h4;
  localparam logic [3:0] DIGIT4    = 4'h5;
  localparam logic [3:0] DIGIT5    = 4'h6;
  localparam logic [3:0] DIGIT6    = 4'h7;
  localparam logic [3:0] DIGIT7    = 4'h8;
  localparam logic [3:0] DECODE    = 4'h9;
  localparam logic [3:0] INTENSITY = 4'hA;
  localparam logic [3:0] SCANLIMIT = 4'hB;
  localparam logic [3:0] SHUTDOWN  = 4'hC;
  localparam logic [3:0] TEST      = 4'hF;

  localparam logic [3:0] CODEB_BLANK = 4'hF;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_UPDATE} ctrl_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_LOAD, TX_SHIFT, TX_GAP} tx_state_t;

  function automatic logic [15:0] frame(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_ctrl_spi_tx16.sv
// One 16-bit MAX7219 frame: LOAD (1) + SHIFT (32*CLK_DIV) + GAP (CLK_DIV) cycles.
// start is honoured only when idle or in the last GAP cycle (done), so frames chain gap-free.
module spi_tx16
  import max7219_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] word,
  output logic        done,
  output logic        sck,
  output logic        cs,
  output logic        din
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  tx_state_t     state, state_nxt;
  logic [15:0]   sreg, sreg_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          ph, ph_nxt;
  logic [3:0]    bitn, bitn_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= TX_IDLE;
      sreg  <= '0;
      cnt   <= '0;
      ph    <= 1'b0;
      bitn  <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
      ph    <= ph_nxt;
      bitn  <= bitn_nxt;
    end
  end

  // ph selects the sck half-period; the word shifts at the end of each high half.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    ph_nxt    = ph;
    bitn_nxt  = bitn;
    case (state)
      TX_IDLE: begin
        if (start) begin
          state_nxt = TX_LOAD;
          sreg_nxt  = word;
        end
      end
      TX_LOAD: begin
        state_nxt = TX_SHIFT;
        cnt_nxt   = '0;
        ph_nxt    = 1'b0;
        bitn_nxt  = '0;
      end
      TX_SHIFT: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          ph_nxt  = ~ph;
          if (ph) begin
            sreg_nxt = {sreg[14:0], 1'b0};
            bitn_nxt = bitn + 4'd1;
            if (bitn == 4'hF) state_nxt = TX_GAP;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      TX_GAP: begin
        if (cnt == CNT_LAST) begin
          cnt_nxt = '0;
          if (start) begin
            state_nxt = TX_LOAD;
            sreg_nxt  = word;
          end else begin
            state_nxt = TX_IDLE;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    done = (state == TX_GAP) && (cnt == CNT_LAST);
    cs   = !((state == TX_LOAD) || (state == TX_SHIFT));
    sck  = (state == TX_SHIFT) && ph;
    din  = ((state == TX_LOAD) || (state == TX_SHIFT)) && sreg[15];
  end

endmodule

// File: rtl/max7219_ctrl.sv
// MAX7219 sequencer: 5-frame init after reset, then DIGIT_NUM+1 frames per accepted latch.
// Latency (DIGIT_NUM+1)*(1+33*CLK_DIV) cycles; latch during a sequence is held as one pending request.
module max7219_ctrl
  import max7219_pkg::*;
#(
  parameter int DIGIT_NUM = 8,
  parameter int CLK_DIV   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   latch,
  input  logic [4*DIGIT_NUM-1:0] num,
  input  logic [2:0]             dp,
  input  logic [3:0]             brightness,
  output logic                   busy,
  output logic                   sck,
  output logic                   cs,
  output logic                   din
);

  localparam logic [3:0] LAST_INIT = 4'd4;
  localparam logic [3:0] LAST_UPD  = 4'(DIGIT_NUM);

  ctrl_state_t            state, state_nxt;
  logic [3:0]             fidx, fidx_nxt;
  logic                   kick, kick_nxt;
  logic                   pend, pend_nxt;
  logic                   take;
  logic [4*DIGIT_NUM-1:0] num_snap;
  logic [2:0]             dp_snap;
  logic [3:0]             bri_snap;
  logic                   start, done;
  logic [15:0]            word;

  function automatic logic [15:0] init_word(input logic [3:0] idx, input logic [3:0] b);
    case (idx)
      4'd0:    return frame(SHUTDOWN, 8'h01);
      4'd1:    return frame(TEST, 8'h00);
      4'd2:    return frame(DECODE, 8'hFF);
      4'd3:    return frame(SCANLIMIT, 8'(DIGIT_NUM - 1));
      default: return frame(INTENSITY, {4'h0, b});
    endcase
  endfunction

  // Frame 0 is intensity; frame k drives digit register k with its nibble.
  function automatic logic [15:0] upd_word(input logic [3:0] idx, input logic [4*DIGIT_NUM-1:0] n,
                                           input logic [2:0] d, input logic [3:0] b);
    logic [3:0] k;
    logic       hit;
    if (idx == 4'd0) return frame(INTENSITY, {4'h0, b});
    k   = idx - 4'd1;
    hit = ({1'b0, d} == k);
    return frame(DIGIT0 + k, {hit, 3'b000, n[4*k +: 4]});
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_INIT;
      fidx     <= '0;
      kick     <= 1'b1;
      pend     <= 1'b0;
      num_snap <= '0;
      dp_snap  <= '0;
      bri_snap <= '0;
    end else begin
      state <= state_nxt;
      fidx  <= fidx_nxt;
      kick  <= kick_nxt;
      pend  <= pend_nxt;
      if (take) begin
        num_snap <= num;
        dp_snap  <= dp;
        bri_snap <= brightness;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fidx_nxt  = fidx;
    kick_nxt  = kick;
    take      = 1'b0;
    case (state)
      ST_INIT: begin
        kick_nxt = 1'b0;
        if (done) begin
          if (fidx == LAST_INIT) begin
            fidx_nxt = '0;
            if (pend || latch) begin
              state_nxt = ST_UPDATE;
              take      = 1'b1;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            fidx_nxt = fidx + 4'd1;
          end
        end
      end
      ST_IDLE: begin
        if (latch) begin
          state_nxt = ST_UPDATE;
          fidx_nxt  = '0;
          take      = 1'b1;
        end
      end
      ST_UPDATE: begin
        if (done) begin
          if (fidx == LAST_UPD) begin
            fidx_nxt = '0;
            if (pend || latch) take = 1'b1;
            else state_nxt = ST_IDLE;
          end else begin
            fidx_nxt = fidx + 4'd1;
          end
        end
      end
      default: state_nxt = ST_INIT;
    endcase
    pend_nxt = take ? 1'b0 : (pend || (latch && (state != ST_IDLE)));
  end

  // The first update frame reads live inputs because the snapshot lands on the same edge.
  always_comb begin
    busy  = (state != ST_IDLE);
    start = ((state == ST_INIT) && kick) || take || (done && (state_nxt != ST_IDLE) && !take);
    if (state_nxt == ST_INIT) word = init_word(fidx_nxt, brightness);
    else if (take)            word = upd_word(4'd0, num, dp, brightness);
    else                      word = upd_word(fidx_nxt, num_snap, dp_snap, bri_snap);
  end

  spi_tx16 #(.CLK_DIV(CLK_DIV)) u_tx (
    .clock (clock),
    .reset (reset),
    .start (start),
    .word  (word),
    .done  (done),
    .sck   (sck),
    .cs    (cs),
    .din   (din)
  );

endmodule

// File: tb/tb_max7219_ctrl.sv
// Directed bench for max7219_ctrl: decodes SPI frames and checks init, update, pending and reset behaviour.
module tb_max7219_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        latch;
  logic [31:0] num;
  logic [2:0]  dp;
  logic [3:0]  brightness;
  logic        busy, sck, cs, din;

  int checks = 0;
  int errors = 0;

  logic [15:0] words[$];
  logic [15:0] sh = '0;
  int          nb = 0;
  int          partial = 0;

  max7219_ctrl #(.DIGIT_NUM(8), .CLK_DIV(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .latch      (latch),
    .num        (num),
    .dp         (dp),
    .brightness (brightness),
    .busy       (busy),
    .sck        (sck),
    .cs         (cs),
    .din        (din)
  );

  always #5 clock = ~clock;

  always @(negedge cs) nb = 0;
  always @(posedge sck) begin
    sh = {sh[14:0], din};
    nb = nb + 1;
  end
  always @(posedge cs) begin
    if (nb == 16) words.push_back(sh);
    else if (nb != 0) partial = partial + 1;
    nb = 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc;
    int first_low;
    logic [15:0] exp_upd[9];

    reset = 1'b0; latch = 1'b0; num = '0; dp = '0; brightness = 4'h5;
    #12;
    check("rst_sck", 32'(sck), 32'h0);
    check("rst_cs", 32'(cs), 32'h1);
    check("rst_din", 32'(din), 32'h0);
    check("rst_busy", 32'(busy), 32'h1);

    // Init sequence after reset release
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    check("init_cs_low", 32'(cs), 32'h0);
    cyc = 0;
    while (busy && cyc < 2000) begin @(posedge clock); #1; cyc++; end
    check("init_len", 32'(cyc), 32'd665);
    check("init_nwords", 32'(words.size()), 32'd5);
    check("init_w0", 32'(words[0]), 32'h0C01);
    check("init_w1", 32'(words[1]), 32'h0F00);
    check("init_w2", 32'(words[2]), 32'h09FF);
    check("init_w3", 32'(words[3]), 32'h0B07);
    check("init_w4", 32'(words[4]), 32'h0A05);

    // Update with num changed mid-sequence
    words.delete();
    num = 32'h1234_5678; dp = 3'd3; brightness = 4'hA;
    repeat (3) @(posedge clock);
    #1; latch = 1'b1;
    @(posedge clock); #1; latch = 1'b0;
    check("upd_busy_n1", 32'(busy), 32'h1);
    check("upd_cs_n1", 32'(cs), 32'h0);
    cyc = 0;
    while (busy && cyc < 3000) begin
      @(posedge clock); #1; cyc++;
      if (cyc == 300) begin num = 32'hDEAD_BEEF; dp = 3'd0; brightness = 4'h1; end
    end
    check("upd_len", 32'(cyc), 32'd1197);
    exp_upd = '{16'h0A0A, 16'h0108, 16'h0207, 16'h0306, 16'h0485, 16'h0504, 16'h0603, 16'h0702, 16'h0801};
    check("upd_nwords", 32'(words.size()), 32'd9);
    for (int i = 0; i < 9; i++) check($sformatf("upd_w%0d", i), 32'(words[i]), 32'(exp_upd[i]));

    // Blank digits with decimal point on MSD
    words.delete();
    num = 32'hFFFF_FF12; dp = 3'd7; brightness = 4'hA;
    latch = 1'b1;
    @(posedge clock); #1; latch = 1'b0;
    cyc = 0;
    while (busy && cyc < 3000) begin @(posedge clock); #1; cyc++; end
    check("blank_nwords", 32'(words.size()), 32'd9);
    check("blank_w1", 32'(words[1]), 32'h0102);
    check("blank_w2", 32'(words[2]), 32'h0201);
    for (int i = 3; i < 8; i++) check($sformatf("blank_w%0d", i), 32'(words[i]), 32'((i << 8) | 8'h0F));
    check("blank_w8", 32'(words[8]), 32'h088F);

    // Reset asserted while sck is high in the first update frame
    latch = 1'b1;
    @(posedge clock); #1; latch = 1'b0;
    cyc = 0;
    while (!sck && cyc < 100) begin @(posedge clock); #1; cyc++; end
    check("midshift_sck_hi", 32'(sck), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("midrst_cs", 32'(cs), 32'h1);
    check("midrst_sck", 32'(sck), 32'h0);
    check("midrst_busy", 32'(busy), 32'h1);
    check("midrst_partial", 32'(partial), 32'd1);
    repeat (3) @(posedge clock);
    words.delete();
    num = 32'h0000_0001; dp = 3'd0; brightness = 4'h3;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;

    // Pending requests: one during init, two during update 1
    cyc = 0;
    first_low = -1;
    while (cyc < 3400) begin
      latch = (cyc == 100 || cyc == 1000 || cyc == 1100);
      if (cyc == 1800) begin num = 32'h0000_0022; dp = 3'd1; brightness = 4'h4; end
      if (cyc == 2000) begin num = 32'h9999_9999; dp = 3'd5; brightness = 4'hF; end
      @(posedge clock); #1; cyc++;
      if (!busy && first_low < 0) first_low = cyc;
    end
    latch = 1'b0;
    check("pend_busy_drop", 32'(first_low), 32'd3059);
    check("pend_nwords", 32'(words.size()), 32'd23);
    check("pend_init0", 32'(words[0]), 32'h0C01);
    check("pend_init4", 32'(words[4]), 32'h0A03);
    check("pend_u1_w0", 32'(words[5]), 32'h0A03);
    check("pend_u1_w1", 32'(words[6]), 32'h0181);
    check("pend_u1_w2", 32'(words[7]), 32'h0200);
    check("pend_u2_w0", 32'(words[14]), 32'h0A04);
    check("pend_u2_w1", 32'(words[15]), 32'h0102);
    check("pend_u2_w2", 32'(words[16]), 32'h0282);
    check("pend_u2_w8", 32'(words[22]), 32'h0800);
    check("pend_partial", 32'(partial), 32'd1);
    check("end_cs_idle", 32'(cs), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
